// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - five-state Moore controller for the small-calculator datapath
// Sequences load A, load B, execute and present; counts completed operations.
module calc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [1:0] op,
  input  logic       ack,
  output logic [1:0] s1,
  output logic [1:0] wa,
  output logic       we,
  output logic [1:0] raa,
  output logic [1:0] rab,
  output logic       rea,
  output logic       reb,
  output logic [1:0] c,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [7:0] op_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] OUT    = 3'd4;

  logic [2:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = LOAD_A;
          op_d    = op;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = EXEC;
      EXEC:   state_d = OUT;
      OUT: begin
        if (ack) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control outputs depend on the state register alone, never on go/op/ack.
  always_comb begin
    s1   = 2'b00;
    wa   = 2'b00;
    we   = 1'b0;
    raa  = 2'b00;
    rea  = 1'b0;
    rab  = 2'b00;
    reb  = 1'b0;
    s2   = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (state_q)
      LOAD_A: begin
        s1  = 2'b11;
        we  = 1'b1;
        raa = 2'b01;
      end
      LOAD_B: begin
        s1  = 2'b10;
        wa  = 2'b01;
        we  = 1'b1;
        raa = 2'b01;
      end
      EXEC: begin
        wa  = 2'b10;
        we  = 1'b1;
        rea = 1'b1;
        rab = 2'b01;
        reb = 1'b1;
      end
      OUT: begin
        s1   = 2'b01;
        wa   = 2'b10;
        rea  = 1'b1;
        rab  = 2'b01;
        reb  = 1'b1;
        s2   = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign c      = op_q;
  assign op_cnt = cnt_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - randomized self-checking bench for calc_ctrl with a 3-bit datapath attached
module tb_calc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, go, ack;
  logic [1:0] op;
  logic [1:0] s1, wa, raa, rab, c;
  logic       we, rea, reb, s2, busy, done;
  logic [7:0] op_cnt;

  logic [2:0] in1, in2;
  logic [2:0] rf [4];
  logic [2:0] a_v, b_v, alu_y, mux_y, dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .go(go), .op(op), .ack(ack),
    .s1(s1), .wa(wa), .we(we), .raa(raa), .rab(rab), .rea(rea), .reb(reb),
    .c(c), .s2(s2), .busy(busy), .done(done), .op_cnt(op_cnt)
  );

  function automatic logic [2:0] alu(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b);
    case (o)
      2'b00:   return 3'((int'(a) + int'(b)) % 8);
      2'b01:   return 3'((int'(a) - int'(b) + 8) % 8);
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Datapath: 4x3-bit register file, input mux, ALU, output mux.
  assign a_v   = rea ? rf[raa] : 3'd0;
  assign b_v   = reb ? rf[rab] : 3'd0;
  assign alu_y = alu(c, a_v, b_v);
  assign mux_y = (s1 == 2'b11) ? in1 : (s1 == 2'b10) ? in2 : alu_y;
  assign dout  = s2 ? alu_y : 3'd0;

  initial for (int i = 0; i < 4; i++) rf[i] = 3'd0;
  always @(posedge clk) if (we) rf[wa] <= mux_y;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..4 the busy cycles, 4 presenting the result.
  int         phase = 0;
  logic [1:0] m_op  = 2'b00;
  logic [2:0] m_a   = 3'd0, m_b = 3'd0;
  int         m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      m_op  = 2'b00;
      m_cnt = 0;
    end else if (phase == 0) begin
      if (go) begin
        phase = 1;
        m_op  = op;
        m_a   = in1;
        m_b   = in2;
      end
    end else if (phase < 4) begin
      phase++;
    end else if (ack) begin
      phase = 0;
      m_cnt = (m_cnt + 1) % 256;
    end
  end

  // {s1,wa,we,raa,rea,rab,reb,s2,busy,done} for each phase.
  function automatic logic [13:0] exp_ctl(input int p);
    case (p)
      1:       return {2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
      2:       return {2'b10, 2'b01, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
      3:       return {2'b00, 2'b10, 1'b1, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
      4:       return {2'b01, 2'b10, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1};
      default: return 14'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ctl", int'({s1, wa, we, raa, rea, rab, reb, s2, busy, done}), int'(exp_ctl(phase)));
      chk("c", int'(c), int'(m_op));
      chk("op_cnt", int'(op_cnt), m_cnt);
      if (phase == 4) chk("dout", int'(dout), int'(alu(m_op, m_a, m_b)));
    end
  end

  task automatic start(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    go = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic finish_op(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      go = 1'($urandom);
      op = 2'($urandom);
    end
    @(negedge clk);
    go = 1'b0; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                        input int exp, input int hold);
    start(o, a, b);
    repeat (3) @(posedge clk);
    #1;
    chk("run_done", int'(done), 1);
    chk("run_dout", int'(dout), exp);
    finish_op(hold);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; ack = 1'b0; op = 2'b00; in1 = 3'd0; in2 = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(op_cnt), 0);
    chk("rst_c", int'(c), 0);
    rst_n = 1'b1;

    // 3 + 2 with fixed latency
    start(2'b00, 3'd3, 3'd2);
    chk("la_s1", int'(s1), 3);
    @(posedge clk); #1;
    chk("lb_s1", int'(s1), 2);
    @(posedge clk); #1;
    chk("ex_we_wa", int'({we, wa}), 6);
    chk("ex_done", int'(done), 0);
    @(posedge clk); #1;
    chk("out_done", int'(done), 1);
    chk("out_dout", int'(dout), 5);
    finish_op(0);
    chk("cnt_after_first", int'(op_cnt), 1);
    chk("idle_after_ack", int'(busy), 0);

    run_op(2'b01, 3'd2, 3'd5, 5, 0);
    run_op(2'b10, 3'd6, 3'd3, 2, 1);
    run_op(2'b11, 3'd6, 3'd3, 5, 0);
    chk("cnt_four", int'(op_cnt), 4);

    // Long hold in OUT with go/op noise
    start(2'b10, 3'd6, 3'd3);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      go = 1'b1; op = 2'b11;
    end
    #1;
    chk("hold_c", int'(c), 2);
    chk("hold_done", int'(done), 1);
    chk("hold_dout", int'(dout), 2);
    finish_op(0);
    @(posedge clk); #1;
    chk("no_restart", int'(busy), 0);

    // Reset during EXEC
    start(2'b01, 3'd5, 3'd1);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_we", int'(we), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_we", int'(we), 0);
    chk("mid_rst_rea", int'({rea, reb}), 0);
    chk("mid_rst_c", int'(c), 0);
    chk("mid_rst_cnt", int'(op_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap after 256 completed operations
    for (int n = 0; n < 256; n++) begin
      logic [1:0] o;
      logic [2:0] a, b;
      o = 2'($urandom); a = 3'($urandom); b = 3'($urandom);
      run_op(o, a, b, int'(alu(o, a, b)), int'($urandom_range(0, 2)));
      if (n == 254) chk("cnt_255", int'(op_cnt), 255);
    end
    chk("cnt_wrap", int'(op_cnt), 0);

    // go and ack together in OUT
    start(2'b00, 3'd1, 3'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    go = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("goack_idle", int'(busy), 0);
    @(posedge clk); #1;
    go = 1'b0;
    chk("goack_restart", int'(s1), 3);
    repeat (3) @(posedge clk);
    #1;
    chk("goack_dout", int'(dout), 2);
    finish_op(0);
    chk("goack_cnt", int'(op_cnt), 2);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
